// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_pkg
// Purpose  : Shared types and constants for the radix-4 Booth multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } booth_state_e;

    // Digit control: zero forces a null addend, two selects 2A, neg subtracts.
    typedef struct packed {
        logic zero;
        logic two;
        logic neg;
    } booth_ctrl_t;

    localparam int BOOTH_MIN_WIDTH = 4;

    function automatic int booth_steps(input int width);
        return width / 2 + 1;
    endfunction

endpackage : booth_pkg
`default_nettype wire

// File: rtl/booth_r4_recoder.sv
`default_nettype none
// ============================================================================
// Module   : booth_r4_recoder
// Purpose  : Maps a radix-4 Booth triplet {b[2i+1], b[2i], b[2i-1]} to a digit.
// Revision : 1.0 - initial release
// ============================================================================
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0]  i_triplet,
    output booth_ctrl_t o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_triplet)
            3'b000, 3'b111: o_ctrl.zero = 1'b1;
            3'b001, 3'b010: o_ctrl.zero = 1'b0;
            3'b011:         o_ctrl.two  = 1'b1;
            3'b100: begin
                o_ctrl.two = 1'b1;
                o_ctrl.neg = 1'b1;
            end
            3'b101, 3'b110: o_ctrl.neg  = 1'b1;
            default:        o_ctrl      = '0;
        endcase
    end

endmodule : booth_r4_recoder
`default_nettype wire

// File: rtl/booth_r4_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth_r4_mul_seq
// Purpose  : Iterative radix-4 Booth multiplier, signed/unsigned per operation.
// Revision : 1.0 - initial release
// ============================================================================
module booth_r4_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int STEPS = booth_steps(WIDTH);
    localparam int EXT_W = WIDTH + 2;
    localparam int ACC_W = EXT_W + 2;
    localparam int CNT_W = $clog2(STEPS + 1);

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(STEPS);

    booth_state_e        r_state;
    booth_state_e        w_next_state;

    logic [EXT_W-1:0]    r_a;
    logic [ACC_W-1:0]    r_hi;
    logic [EXT_W-1:0]    r_lo;
    logic                r_bm1;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*WIDTH-1:0]  r_product;
    logic                r_out_valid;

    logic [EXT_W-1:0]    w_a_ext;
    logic [EXT_W-1:0]    w_b_ext;
    logic [2:0]          w_triplet;
    booth_ctrl_t         w_ctrl;
    logic [ACC_W-1:0]    w_a_acc;
    logic [ACC_W-1:0]    w_mag;
    logic [ACC_W-1:0]    w_addend;
    logic [ACC_W-1:0]    w_sum;
    logic [ACC_W-1:0]    w_hi_next;
    logic [EXT_W-1:0]    w_lo_next;
    logic                w_last;

    // Mode is folded into the operand extension at accept, so it needs no register.
    assign w_a_ext = {{2{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
    assign w_b_ext = {{2{signed_mode & multiplier[WIDTH-1]}},   multiplier};

    assign w_triplet = {r_lo[1:0], r_bm1};

    booth_r4_recoder u_recoder (
        .i_triplet (w_triplet),
        .o_ctrl    (w_ctrl)
    );

    // Negative digits use inversion here plus a carry-in on the adder.
    assign w_a_acc   = {{2{r_a[EXT_W-1]}}, r_a};
    assign w_mag     = w_ctrl.zero ? '0 : (w_ctrl.two ? (w_a_acc << 1) : w_a_acc);
    assign w_addend  = w_ctrl.neg ? ~w_mag : w_mag;
    assign w_sum     = r_hi + w_addend + {{(ACC_W-1){1'b0}}, w_ctrl.neg};
    assign w_hi_next = {{2{w_sum[ACC_W-1]}}, w_sum[ACC_W-1:2]};
    assign w_lo_next = {w_sum[1:0], r_lo[EXT_W-1:2]};

    assign w_last = (r_cnt == c_last_cnt);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next_state = CALC;
            CALC:    if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    // The cycle after the final step only transfers the accumulator into the product.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a         <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_bm1       <= 1'b0;
            r_cnt       <= '0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a   <= w_a_ext;
                        r_lo  <= w_b_ext;
                        r_hi  <= '0;
                        r_bm1 <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                CALC: begin
                    if (w_last) begin
                        r_product   <= {r_hi[WIDTH-3:0], r_lo};
                        r_out_valid <= 1'b1;
                    end else begin
                        r_hi  <= w_hi_next;
                        r_lo  <= w_lo_next;
                        r_bm1 <= r_lo[1];
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign product   = r_product;

endmodule : booth_r4_mul_seq
`default_nettype wire

// File: tb/tb_booth_r4_mul_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_booth_r4_mul_seq
// Purpose  : Scoreboard bench for the 8- and 16-bit multiplier and the recoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_r4_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv8, ir8, sm8, ov8, or8, bz8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        iv16, ir16, sm16, ov16, or16, bz16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    logic [2:0]  rec_in, rec_out;

    booth_r4_mul_seq #(.WIDTH(8)) u_dut8 (
        .CLK(clk), .RST(rst), .in_valid(iv8), .in_ready(ir8),
        .multiplicand(a8), .multiplier(b8), .signed_mode(sm8),
        .out_valid(ov8), .out_ready(or8), .product(p8), .busy(bz8)
    );

    booth_r4_mul_seq #(.WIDTH(16)) u_dut16 (
        .CLK(clk), .RST(rst), .in_valid(iv16), .in_ready(ir16),
        .multiplicand(a16), .multiplier(b16), .signed_mode(sm16),
        .out_valid(ov16), .out_ready(or16), .product(p16), .busy(bz16)
    );

    booth_r4_recoder u_rec (
        .i_triplet(rec_in),
        .o_ctrl   (rec_out)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] q8[$];
    logic [31:0] q16[$];

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic s, input int w);
        longint aa, bb, pp;
        aa = longint'(a);
        bb = longint'(b);
        if (s && a[w-1]) aa = aa - (longint'(1) << w);
        if (s && b[w-1]) bb = bb - (longint'(1) << w);
        pp = aa * bb;
        return pp[31:0];
    endfunction

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int n;
        logic [31:0] r;
        n = 0;
        while (!ir8 && n < 50) begin @(posedge clk); #1; n++; end
        a8 = a; b8 = b; sm8 = s; iv8 = 1'b1;
        r = ref_mul({8'h00, a}, {8'h00, b}, s, 8);
        q8.push_back(r[15:0]);
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic wait8(output int lat, output int busy_low);
        lat = 0; busy_low = 0;
        while (!ov8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (!bz8) busy_low++;
        end
    endtask

    task automatic retire8();
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic s);
        int n;
        n = 0;
        while (!ir16 && n < 50) begin @(posedge clk); #1; n++; end
        a16 = a; b16 = b; sm16 = s; iv16 = 1'b1;
        q16.push_back(ref_mul(a, b, s, 16));
        @(posedge clk); #1;
        iv16 = 1'b0;
    endtask

    // out_ready toggles freely while calculating; it only matters in DONE.
    task automatic wait16(output int lat);
        lat = 0;
        while (!ov16 && lat < 60) begin
            or16 = ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire16_random();
        int  tries;
        logic r;
        tries = 0;
        do begin
            r = (tries >= 4) ? 1'b1 : ($urandom_range(0, 1) == 1);
            or16 = r;
            @(posedge clk); #1;
            tries++;
        end while (!r);
        or16 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (ir8 !== 1'b1)    begin errors++; $display("FAIL reset_in_ready8: got %b want 1", ir8); end
        checks++; if (ov8 !== 1'b0)    begin errors++; $display("FAIL reset_out_valid8: got %b want 0", ov8); end
        checks++; if (p8 !== 16'h0)    begin errors++; $display("FAIL reset_product8: got %h want 0000", p8); end
        checks++; if (bz8 !== 1'b0)    begin errors++; $display("FAIL reset_busy8: got %b want 0", bz8); end
        checks++; if (ir16 !== 1'b1)   begin errors++; $display("FAIL reset_in_ready16: got %b want 1", ir16); end
        checks++; if (ov16 !== 1'b0)   begin errors++; $display("FAIL reset_out_valid16: got %b want 0", ov16); end
        checks++; if (p16 !== 32'h0)   begin errors++; $display("FAIL reset_product16: got %h want 0", p16); end
        checks++; if (bz16 !== 1'b0)   begin errors++; $display("FAIL reset_busy16: got %b want 0", bz16); end
    endtask

    task automatic test_recoder();
        logic [2:0] tab [8];
        logic [2:0] code;
        tab = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b011, 3'b001, 3'b001, 3'b100};
        for (int i = 0; i < 8; i++) begin
            code   = 3'(i);
            rec_in = code;
            #1;
            checks++;
            if (rec_out !== tab[i]) begin
                errors++;
                $display("FAIL recoder_%b: got {zero,two,neg}=%b want %b", code, rec_out, tab[i]);
            end
        end
    endtask

    task automatic test_signed_min();
        int lat, bl;
        logic [15:0] exp;
        start8(8'h80, 8'h80, 1'b1);
        wait8(lat, bl);
        exp = q8.pop_front();
        checks++; if (lat != 6)  begin errors++; $display("FAIL latency8: got %0d edges want 6", lat); end
        checks++; if (bl != 0)   begin errors++; $display("FAIL busy_calc8: busy low in %0d cycles want 0", bl); end
        checks++; if (p8 !== exp || exp !== 16'h4000) begin errors++; $display("FAIL prod_80x80s: got %h want 4000", p8); end
        retire8();
        checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0) begin errors++; $display("FAIL retire8: in_ready=%b out_valid=%b want 1/0", ir8, ov8); end
    endtask

    task automatic test_unsigned();
        int lat, bl;
        logic [15:0] exp;
        start8(8'hFF, 8'hFF, 1'b0);
        wait8(lat, bl);
        exp = q8.pop_front();
        checks++; if (p8 !== exp || exp !== 16'hFE01) begin errors++; $display("FAIL prod_FFxFFu: got %h want FE01", p8); end
        retire8();
        start8(8'hFF, 8'hFF, 1'b1);
        wait8(lat, bl);
        exp = q8.pop_front();
        checks++; if (p8 !== exp || exp !== 16'h0001) begin errors++; $display("FAIL prod_FFxFFs: got %h want 0001", p8); end
        checks++; if (lat != 6) begin errors++; $display("FAIL latency8_signed: got %0d want 6", lat); end
        retire8();
    endtask

    task automatic test_mode_latch();
        int lat, bl;
        logic [15:0] exp;
        start8(8'h7F, 8'h80, 1'b1);
        repeat (3) begin
            sm8 = ~sm8; a8 = 8'($urandom); b8 = 8'($urandom); iv8 = ~iv8;
            @(posedge clk); #1;
        end
        iv8 = 1'b0;
        wait8(lat, bl);
        exp = q8.pop_front();
        checks++; if (p8 !== exp || exp !== 16'hC080) begin errors++; $display("FAIL prod_7Fx80s_latched: got %h want C080", p8); end
        retire8();
    endtask

    task automatic test_backpressure();
        int lat, bl, bad, spur;
        logic [15:0] exp;
        start8(8'hA5, 8'h3C, 1'b0);
        wait8(lat, bl);
        exp = q8.pop_front();
        bad = 0;
        repeat (10) begin
            iv8 = ~iv8; a8 = 8'($urandom); b8 = 8'($urandom);
            @(posedge clk); #1;
            if (p8 !== exp || ov8 !== 1'b1 || ir8 !== 1'b0 || bz8 !== 1'b1) bad++;
        end
        iv8 = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold: %0d unstable cycles want 0 (prod %h want %h)", bad, p8, exp); end
        retire8();
        checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0) begin errors++; $display("FAIL stall_release: in_ready=%b out_valid=%b want 1/0", ir8, ov8); end
        spur = 0;
        repeat (10) begin @(posedge clk); #1; if (ov8 || bz8) spur++; end
        checks++; if (spur != 0) begin errors++; $display("FAIL stall_ignored_valid: %0d busy cycles want 0", spur); end
    endtask

    task automatic test_reset_mid();
        int lat, bl, spur;
        logic [15:0] exp;
        start8(8'h55, 8'h66, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(q8.pop_back());
        checks++; if (ov8 !== 1'b0 || p8 !== 16'h0 || bz8 !== 1'b0 || ir8 !== 1'b1) begin
            errors++; $display("FAIL reset_mid: ov=%b prod=%h busy=%b rdy=%b want 0/0000/0/1", ov8, p8, bz8, ir8);
        end
        spur = 0;
        repeat (10) begin @(posedge clk); #1; if (ov8) spur++; end
        checks++; if (spur != 0) begin errors++; $display("FAIL reset_mid_no_output: %0d valid cycles want 0", spur); end
        start8(8'h03, 8'hFB, 1'b1);
        wait8(lat, bl);
        exp = q8.pop_front();
        checks++; if (p8 !== exp || exp !== 16'hFFF1) begin errors++; $display("FAIL prod_03xFBs: got %h want FFF1", p8); end
        checks++; if (lat != 6) begin errors++; $display("FAIL latency8_after_reset: got %0d want 6", lat); end
        retire8();
    endtask

    task automatic test_back_to_back();
        int sent, got;
        logic [31:0] r;
        logic [15:0] exp;
        logic s;
        sent = 0; got = 0;
        or8 = 1'b1;
        for (int cyc = 0; cyc < 500 && got < 20; cyc++) begin
            if (ov8) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++; $display("FAIL b2b_spurious: product %h with empty scoreboard", p8);
                end else begin
                    exp = q8.pop_front();
                    if (p8 !== exp) begin errors++; $display("FAIL b2b_prod%0d: got %h want %h", got, p8, exp); end
                end
                got++;
            end
            if (ir8 && sent < 20) begin
                a8 = 8'($urandom); b8 = 8'($urandom); s = ($urandom_range(0, 1) == 1); sm8 = s;
                r = ref_mul({8'h00, a8}, {8'h00, b8}, s, 8);
                q8.push_back(r[15:0]);
                iv8 = 1'b1;
                sent++;
            end else begin
                iv8 = 1'b0;
            end
            @(posedge clk); #1;
        end
        iv8 = 1'b0; or8 = 1'b0;
        checks++; if (got != 20) begin errors++; $display("FAIL b2b_count: got %0d results want 20", got); end
    endtask

    task automatic test_wide16();
        int lat;
        logic [31:0] exp;
        start16(16'h8000, 16'h8000, 1'b1);
        wait16(lat);
        exp = q16.pop_front();
        checks++; if (lat != 10) begin errors++; $display("FAIL latency16: got %0d want 10", lat); end
        checks++; if (p16 !== exp || exp !== 32'h40000000) begin errors++; $display("FAIL prod16_min: got %h want 40000000", p16); end
        retire16_random();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 200; k++) begin
                start16(16'($urandom), 16'($urandom), (m == 1));
                wait16(lat);
                exp = q16.pop_front();
                checks++;
                if (lat != 10 || p16 !== exp) begin
                    errors++;
                    $display("FAIL rand16_m%0d_%0d: %h x %h got %h lat %0d want %h lat 10", m, k, a16, b16, p16, lat, exp);
                end
                retire16_random();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        iv16 = 1'b0; or16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        rec_in = '0;
        test_reset();
        test_recoder();
        test_signed_min();
        test_unsigned();
        test_mode_latch();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_wide16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_booth_r4_mul_seq
`default_nettype wire
